// File: rtl/mips_defs.sv
// Shared MIPS decode constants: ALU operation codes, opcode/funct values and
// the immediate extension helper used by the operand stage.
package mips_defs;

  localparam int DATA_W = 32;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic sign_ext);
    logic signed [15:0] simm;
    logic signed [31:0] swide;
    simm  = imm;
    swide = 32'(simm);
    return sign_ext ? swide : {16'h0000, imm};
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file, two combinational read ports and one synchronous write
// port; $0 is hardwired to zero and same-cycle writes bypass to the readers.
module reg_file
  import mips_defs::*;
#(
  parameter int DATA_W            = 32,
  parameter bit RF_CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [4:0]        waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [4:0]        raddr_a,
  output logic [DATA_W-1:0] rdata_a,
  input  logic [4:0]        raddr_b,
  output logic [DATA_W-1:0] rdata_b
);

  logic [DATA_W-1:0] regs_q [32];
  logic              wr_live;

  assign wr_live = we && (waddr != 5'd0);

  generate
    if (RF_CLEAR_ON_RESET) begin : g_clr
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < 32; i++) regs_q[i] <= '0;
        end else if (wr_live) begin
          regs_q[waddr] <= wdata;
        end
      end
    end else begin : g_noclr
      always_ff @(posedge clk) begin
        if (wr_live) regs_q[waddr] <= wdata;
      end
    end
  endgenerate

  always_comb begin
    rdata_a = regs_q[raddr_a];
    if (raddr_a == 5'd0)                rdata_a = '0;
    else if (wr_live && waddr == raddr_a) rdata_a = wdata;
  end

  always_comb begin
    rdata_b = regs_q[raddr_b];
    if (raddr_b == 5'd0)                rdata_b = '0;
    else if (wr_live && waddr == raddr_b) rdata_b = wdata;
  end

endmodule

// File: rtl/operand_fetch.sv
// MIPS decode/operand stage: decodes one instruction per handshake, reads rs/rt
// and registers the ALU operands and control in a single output stage.
module operand_fetch
  import mips_defs::*;
#(
  parameter int DATA_W            = 32,
  parameter bit RF_CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       Instr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] In1,
  output logic [DATA_W-1:0] In2,
  output logic [2:0]        ControlSignal,
  output logic [4:0]        WriteReg,
  output logic              RegWrite,
  output logic              Illegal,
  input  logic              WbEn,
  input  logic [4:0]        WbReg,
  input  logic [DATA_W-1:0] WbData
);

  logic [5:0]        opcode, funct;
  logic [4:0]        rs, rt, rd;
  logic [DATA_W-1:0] rs_val, rt_val;
  logic [2:0]        alu_op;
  logic              use_imm, sign_ext, wr_en, illegal, dst_rd;
  logic              accept;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] in1_q, in1_d, in2_q, in2_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [4:0]        wreg_q, wreg_d;
  logic              regwrite_q, regwrite_d, illegal_q, illegal_d;

  assign opcode = Instr[31:26];
  assign rs     = Instr[25:21];
  assign rt     = Instr[20:16];
  assign rd     = Instr[15:11];
  assign funct  = Instr[5:0];

  reg_file #(
    .DATA_W            (DATA_W),
    .RF_CLEAR_ON_RESET (RF_CLEAR_ON_RESET)
  ) u_rf (
    .clk     (clk),
    .reset   (reset),
    .we      (WbEn),
    .waddr   (WbReg),
    .wdata   (WbData),
    .raddr_a (rs),
    .rdata_a (rs_val),
    .raddr_b (rt),
    .rdata_b (rt_val)
  );

  // Unsupported encodings still flow through as R-type shaped, non-writing ADDs.
  always_comb begin
    alu_op   = ALU_ADD;
    use_imm  = 1'b0;
    sign_ext = 1'b1;
    wr_en    = 1'b0;
    illegal  = 1'b0;
    dst_rd   = 1'b0;
    unique case (opcode)
      OP_RTYPE: begin
        dst_rd = 1'b1;
        wr_en  = 1'b1;
        unique case (funct)
          FN_ADD, FN_ADDU: alu_op = ALU_ADD;
          FN_SUB, FN_SUBU: alu_op = ALU_SUB;
          FN_AND:          alu_op = ALU_AND;
          FN_OR:           alu_op = ALU_OR;
          FN_SLT:          alu_op = ALU_SLT;
          default: begin
            illegal = 1'b1;
            wr_en   = 1'b0;
          end
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW: begin use_imm = 1'b1; wr_en = 1'b1; end
      OP_SLTI: begin alu_op = ALU_SLT; use_imm = 1'b1; wr_en = 1'b1; end
      OP_ANDI: begin alu_op = ALU_AND; use_imm = 1'b1; sign_ext = 1'b0; wr_en = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR;  use_imm = 1'b1; sign_ext = 1'b0; wr_en = 1'b1; end
      OP_SW:   use_imm = 1'b1;
      OP_BEQ:  alu_op = ALU_SUB;
      default: begin
        illegal = 1'b1;
        dst_rd  = 1'b1;
      end
    endcase
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    ctrl_d      = ctrl_q;
    wreg_d      = wreg_q;
    regwrite_d  = regwrite_q;
    illegal_d   = illegal_q;
    if (accept) begin
      out_valid_d = 1'b1;
      in1_d       = rs_val;
      in2_d       = use_imm ? ext_imm(Instr[15:0], sign_ext) : rt_val;
      ctrl_d      = alu_op;
      wreg_d      = dst_rd ? rd : rt;
      regwrite_d  = wr_en;
      illegal_d   = illegal;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Output stage boundary
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      in1_q       <= '0;
      in2_q       <= '0;
      ctrl_q      <= ALU_AND;
      wreg_q      <= '0;
      regwrite_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      ctrl_q      <= ctrl_d;
      wreg_q      <= wreg_d;
      regwrite_q  <= regwrite_d;
      illegal_q   <= illegal_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign In1           = in1_q;
  assign In2           = in2_q;
  assign ControlSignal = ctrl_q;
  assign WriteReg      = wreg_q;
  assign RegWrite      = regwrite_q;
  assign Illegal       = illegal_q;

endmodule
